music_streamer: RTL and testbench
=================================

// Module: music_streamer
// PURPOSE
//   Sequencer upstream of tone_generator: walks a tone ROM one entry per beat and drives
//   tone_switch_period (tone) and output_enable. Supports play/pause, forward/reverse
//   direction and run-time tempo adjust. Sits between the button conditioner and the
//   tone_generator in the lab4 audio top level.
// PARAMETERS
//   ADDR_W        10          ROM address width
//   TONE_W        24          tone/half-period word width (matches tone_generator)
//   LAST_ADDR     1023        index of final ROM entry; wrap point
//   BEAT_DEFAULT  5_000_000   clocks per beat after reset (1/25 s at 125 MHz)
//   BEAT_STEP     500_000     tempo adjust step in clocks
//   BEAT_MIN      500_000     minimum clocks per beat (fastest tempo)
//   BEAT_MAX      25_000_000  maximum clocks per beat (slowest tempo)
// PORTS
//   clk          in   1       system clock, 125 MHz
//   rst          in   1       asynchronous reset, active-low (0 = reset)
//   play_pause   in   1       1-cycle pulse, toggles PLAY/PAUSE
//   reverse      in   1       1-cycle pulse, toggles direction
//   tempo_up     in   1       1-cycle pulse, beat length -= BEAT_STEP
//   tempo_down   in   1       1-cycle pulse, beat length += BEAT_STEP
//   rom_addr     out  ADDR_W  address to synchronous tone ROM
//   rom_data     in   TONE_W  ROM word, valid 1 clk after rom_addr
//   tone         out  TONE_W  tone_switch_period to tone_generator
//   output_en    out  1       output_enable to tone_generator
//   state_leds   out  2       {reverse_dir, paused}
// BEHAVIOUR
//   Reset (rst=0, async): rom_addr=0, state=PLAY, dir=FWD, beat_len=BEAT_DEFAULT,
//     beat_cnt=0, tone=0, output_en=0, state_leds=2'b00. All outputs registered.
//   After release: tone=rom_data of addr 0 at 2nd rising edge (1 clk ROM + 1 clk reg);
//     output_en=1 from the same edge while PLAY.
//   States: PLAY <-> PAUSE on play_pause pulse only.
//     PLAY: beat_cnt increments every clk; when beat_cnt >= beat_len-1, beat_cnt<=0 and
//       rom_addr advances (FWD +1, REV -1). tone <= rom_data every clk (2-clk latency
//       from address change).
//     PAUSE: beat_cnt and rom_addr frozen; tone <= 0, output_en <= 0 on next edge.
//       Resume continues from frozen beat_cnt/rom_addr; tone valid 1 clk later.
//   Wrap: FWD at LAST_ADDR -> 0; REV at 0 -> LAST_ADDR.
//   reverse: toggles dir in PLAY or PAUSE; takes effect on next address advance;
//     beat_cnt not cleared.
//   Tempo: tempo_up -> beat_len=max(beat_len-BEAT_STEP, BEAT_MIN);
//     tempo_down -> beat_len=min(beat_len+BEAT_STEP, BEAT_MAX); saturating, no wrap.
//     Accepted in PLAY and PAUSE. If beat_cnt already >= new beat_len-1, advance fires
//     on next edge (compare is >=, never waits for counter overflow).
//   Simultaneous: tempo_up & tempo_down same clk -> beat_len unchanged. play_pause &
//     reverse same clk -> both applied. Pulse coincident with beat advance: advance uses
//     old dir, state change takes effect next clk.
//   Zero tone word in ROM passes through unchanged (tone_generator silences on 0).
//   beat_cnt width = $clog2(BEAT_MAX); arithmetic unsigned.
//   Reset asserted mid-song: all state returns to reset values immediately.
// STRUCTURE
//   Package audio_pkg: TONE_W, CLK_HZ, state encoding (ST_PLAY, ST_PAUSE),
//     tempo constants shared with top level.
//   Sub-module beat_timer: beat_len register + saturating adjust + beat_cnt, outputs
//     1-clk beat_tick; inputs run, tempo_up, tempo_down. Remainder (FSM, address,
//     tone register) in music_streamer.
// TESTING  (bench overrides BEAT_DEFAULT=10, BEAT_STEP=2, BEAT_MIN=4, BEAT_MAX=16,
//           LAST_ADDR=7; ROM model: data = 100*addr+100, 1-clk latency)
//   Reset/first tone: release rst -> tone=100 & output_en=1 at 2nd edge; addr 1 after
//     10 clks, tone=200 two clks later.
//   Wrap FWD/REV: run 8 beats -> addr 7->0, tone 800->100; pulse reverse at addr 0 ->
//     next addr 7, tone=800.
//   Pause/resume: play_pause at beat_cnt=5, addr 3 -> tone=0, output_en=0 next clk; hold
//     50 clks addr stays 3; resume -> advance 5 clks later.
//   Tempo saturate: 5x tempo_up -> beat_len=4 (beat every 4 clks); 10x tempo_down ->
//     16; tempo_up & tempo_down same clk -> unchanged.
//   Shrink mid-beat: beat_len=16, beat_cnt=12, tempo_up x3 -> beat_len=10, addr
//     advances on next edge.
//   Async reset mid-song: drop rst between edges at addr 5 -> outputs zero immediately
//     without clock edge; addr=0 on release.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants, tempo defaults and play-state encoding
package audio_pkg;

    localparam int TONE_W            = 24;
    localparam int CLK_HZ            = 125_000_000;
    localparam int BEAT_DEFAULT_CLKS = 5_000_000;
    localparam int BEAT_STEP_CLKS    = 500_000;
    localparam int BEAT_MIN_CLKS     = 500_000;
    localparam int BEAT_MAX_CLKS     = 25_000_000;

    typedef enum logic {
        ST_PLAY  = 1'b0,
        ST_PAUSE = 1'b1
    } play_state_t;

endpackage

// File: rtl/beat_timer.sv
// rtl/beat_timer.sv - beat length register with saturating tempo adjust and beat counter
module beat_timer #(
    parameter int BEAT_DEFAULT = 5_000_000,
    parameter int BEAT_STEP    = 500_000,
    parameter int BEAT_MIN     = 500_000,
    parameter int BEAT_MAX     = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic tempo_up,
    input  logic tempo_down,
    output logic beat_tick
);

    localparam int CNT_W = $clog2(BEAT_MAX);
    localparam int LEN_W = $clog2(BEAT_MAX + 1);

    localparam logic [LEN_W-1:0] LEN_DEFAULT = LEN_W'(BEAT_DEFAULT);
    localparam logic [LEN_W-1:0] LEN_STEP    = LEN_W'(BEAT_STEP);
    localparam logic [LEN_W-1:0] LEN_MIN     = LEN_W'(BEAT_MIN);
    localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(BEAT_MAX);

    logic [LEN_W-1:0] beat_len;
    logic [LEN_W-1:0] len_dec;
    logic [LEN_W-1:0] len_inc;
    logic [CNT_W-1:0] beat_cnt;

    // Headroom is measured against the limits so the adjust can never wrap.
    assign len_dec = (beat_len - LEN_MIN >= LEN_STEP) ? beat_len - LEN_STEP : LEN_MIN;
    assign len_inc = (LEN_MAX - beat_len >= LEN_STEP) ? beat_len + LEN_STEP : LEN_MAX;

    // >= rather than == so a shortened beat fires at once instead of waiting for overflow.
    assign beat_tick = run && (LEN_W'(beat_cnt) >= beat_len - LEN_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_len <= LEN_DEFAULT;
            beat_cnt <= '0;
        end else begin
            if (tempo_up && !tempo_down) begin
                beat_len <= len_dec;
            end else if (tempo_down && !tempo_up) begin
                beat_len <= len_inc;
            end
            if (run) begin
                beat_cnt <= beat_tick ? '0 : beat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/music_streamer.sv
// rtl/music_streamer.sv - tone ROM sequencer with play/pause, direction and tempo control
module music_streamer #(
    parameter int ADDR_W       = 10,
    parameter int TONE_W       = audio_pkg::TONE_W,
    parameter int LAST_ADDR    = 1023,
    parameter int BEAT_DEFAULT = audio_pkg::BEAT_DEFAULT_CLKS,
    parameter int BEAT_STEP    = audio_pkg::BEAT_STEP_CLKS,
    parameter int BEAT_MIN     = audio_pkg::BEAT_MIN_CLKS,
    parameter int BEAT_MAX     = audio_pkg::BEAT_MAX_CLKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play_pause,
    input  logic              reverse,
    input  logic              tempo_up,
    input  logic              tempo_down,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [TONE_W-1:0] rom_data,
    output logic [TONE_W-1:0] tone,
    output logic              output_en,
    output logic [1:0]        state_leds
);

    import audio_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    play_state_t       state;
    logic              rev_dir;
    logic              rom_valid;
    logic              playing;
    logic              beat_tick;
    logic [ADDR_W-1:0] next_addr;

    assign playing    = (state == ST_PLAY);
    assign state_leds = {rev_dir, (state == ST_PAUSE)};

    beat_timer #(
        .BEAT_DEFAULT (BEAT_DEFAULT),
        .BEAT_STEP    (BEAT_STEP),
        .BEAT_MIN     (BEAT_MIN),
        .BEAT_MAX     (BEAT_MAX)
    ) u_beat_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (playing),
        .tempo_up   (tempo_up),
        .tempo_down (tempo_down),
        .beat_tick  (beat_tick)
    );

    always_comb begin
        next_addr = rom_addr;
        if (!rev_dir) begin
            next_addr = (rom_addr == LAST) ? '0 : rom_addr + ADDR_W'(1);
        end else begin
            next_addr = (rom_addr == '0) ? LAST : rom_addr - ADDR_W'(1);
        end
    end

    // Control pulses update registered state; the advance and outputs on the same
    // edge still see the old state and direction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_PLAY;
            rev_dir   <= 1'b0;
            rom_addr  <= '0;
            rom_valid <= 1'b0;
            tone      <= '0;
            output_en <= 1'b0;
        end else begin
            if (play_pause) begin
                state <= playing ? ST_PAUSE : ST_PLAY;
            end
            if (reverse) begin
                rev_dir <= !rev_dir;
            end
            if (beat_tick) begin
                rom_addr <= next_addr;
            end
            // ROM output is meaningless until one edge after reset release.
            rom_valid <= 1'b1;
            if (playing && rom_valid) begin
                tone      <= rom_data;
                output_en <= 1'b1;
            end else begin
                tone      <= '0;
                output_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_music_streamer.sv
// tb/tb_music_streamer.sv - directed table-driven bench for music_streamer
module tb_music_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        play_pause = 1'b0;
    logic        reverse = 1'b0;
    logic        tempo_up = 1'b0;
    logic        tempo_down = 1'b0;
    logic [9:0]  rom_addr;
    logic [23:0] rom_data = '0;
    logic [23:0] tone;
    logic        output_en;
    logic [1:0]  state_leds;

    int errors = 0;
    int checks = 0;

    music_streamer #(
        .ADDR_W       (10),
        .TONE_W       (24),
        .LAST_ADDR    (7),
        .BEAT_DEFAULT (10),
        .BEAT_STEP    (2),
        .BEAT_MIN     (4),
        .BEAT_MAX     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .play_pause (play_pause),
        .reverse    (reverse),
        .tempo_up   (tempo_up),
        .tempo_down (tempo_down),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .tone       (tone),
        .output_en  (output_en),
        .state_leds (state_leds)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= 24'(100 * int'(rom_addr) + 100);

    typedef struct packed {
        logic       pp;
        logic       rv;
        logic       up;
        logic       dn;
        int         n;
        int         addr;
        int         tone;
        logic       oe;
        logic [1:0] leds;
    } vec_t;

    vec_t vecs [22];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int a, input int t, input int oe, input int leds);
        check({name, "_addr"}, int'(rom_addr), a);
        check({name, "_tone"}, int'(tone), t);
        check({name, "_oe"}, int'(output_en), oe);
        check({name, "_leds"}, int'(state_leds), leds);
    endtask

    task automatic pulse(input logic pp, input logic rv, input logic up, input logic dn);
        play_pause = pp;
        reverse    = rv;
        tempo_up   = up;
        tempo_down = dn;
        tick();
        play_pause = 1'b0;
        reverse    = 1'b0;
        tempo_up   = 1'b0;
        tempo_down = 1'b0;
    endtask

    task automatic wait_advance(output int n);
        logic [9:0] a;
        a = rom_addr;
        n = 0;
        while (rom_addr == a && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_addr(input int target);
        for (int i = 0; i < 400 && int'(rom_addr) != target; i++) tick();
        check("wait_addr", int'(rom_addr), target);
    endtask

    initial begin
        int n;
        int a;

        // Each row: pulse on first edge, n edges total, then expected outputs.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,  1, 0,   0, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0,  1, 0, 100, 1'b1, 2'b00};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0,  8, 1, 100, 1'b1, 2'b00};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0,  2, 1, 200, 1'b1, 2'b00};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 68, 0, 800, 1'b1, 2'b00};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0,  2, 0, 100, 1'b1, 2'b00};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 0, 100, 1'b1, 2'b10};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0,  7, 7, 100, 1'b1, 2'b10};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0,  2, 7, 800, 1'b1, 2'b10};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 6, 700, 1'b1, 2'b10};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 6, 700, 1'b1, 2'b00};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0,  7, 7, 700, 1'b1, 2'b00};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0,  2, 7, 800, 1'b1, 2'b00};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0,  7, 7, 800, 1'b1, 2'b00};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 0, 800, 1'b1, 2'b10};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 10, 7, 100, 1'b1, 2'b10};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0,  2, 7, 800, 1'b1, 2'b10};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 7, 800, 1'b1, 2'b01};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0,  1, 7,   0, 1'b0, 2'b01};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 20, 7,   0, 1'b0, 2'b01};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 7,   0, 1'b0, 2'b00};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0,  1, 7, 800, 1'b1, 2'b00};

        repeat (3) tick();
        check_out("reset", 0, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < 22; i++) begin
            pulse(vecs[i].pp, vecs[i].rv, vecs[i].up, vecs[i].dn);
            repeat (vecs[i].n - 1) tick();
            check_out($sformatf("vec%0d", i), vecs[i].addr, vecs[i].tone,
                      int'(vecs[i].oe), int'(vecs[i].leds));
        end

        // Pause at beat_cnt 5 on addr 3, hold, resume.
        wait_addr(3);
        repeat (4) tick();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("pause_edge", 3, 400, 1, 1);
        tick();
        check_out("paused", 3, 0, 0, 1);
        repeat (50) tick();
        check("pause_hold_addr", int'(rom_addr), 3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check_out("resume_edge", 3, 0, 0, 0);
        tick();
        check_out("resume_tone", 3, 400, 1, 0);
        repeat (3) tick();
        check("resume_before_adv", int'(rom_addr), 3);
        tick();
        check("resume_adv", int'(rom_addr), 4);

        // Tempo saturation at both ends and simultaneous up/down.
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        wait_advance(n);
        wait_advance(n);
        check("beat_min", n, 4);
        for (int i = 0; i < 10; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        wait_advance(n);
        wait_advance(n);
        check("beat_max", n, 16);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        wait_advance(n);
        wait_advance(n);
        check("beat_up_dn", n, 16);

        // Shrink beat below the frozen count: advance fires on the first playing edge.
        a = int'(rom_addr);
        repeat (11) tick();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("shrink_paused_addr", int'(rom_addr), a);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("shrink_resume_addr", int'(rom_addr), a);
        tick();
        check("shrink_adv", int'(rom_addr), (a + 1) % 8);
        wait_advance(n);
        check("beat_after_shrink", n, 10);

        // Asynchronous reset mid-song, between edges.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        wait_addr(5);
        check("pre_reset_leds", int'(state_leds), 2);
        #2;
        rst = 1'b0;
        #1;
        check_out("async_reset", 0, 0, 0, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_out("rerelease_1", 0, 0, 0, 0);
        tick();
        check_out("rerelease_2", 0, 100, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
